// File: rtl/cordic_pkg.sv
// Shared defaults, the fixed-point unity constant and FSM state encoding for the
// CORDIC tanh divider.
package cordic_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int FRAC_BITS_DEF  = 16;
  localparam int ONE            = 1 << FRAC_BITS_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } tanh_state_e;

endpackage

// File: rtl/cordic_tanh_div_if.sv
// Operand/result handshake bundle for cordic_tanh_div. sigmoid_out exists only
// when TANH_SIGMOID_EN is defined.
interface cordic_tanh_div_if #(
  parameter int DATA_WIDTH = 32
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] cosh_in;
  logic signed [DATA_WIDTH-1:0] sinh_in;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] tanh_out;
  logic                         sat;
  logic                         busy;
`ifdef TANH_SIGMOID_EN
  logic signed [DATA_WIDTH-1:0] sigmoid_out;
`endif

  modport slave (
    input  in_valid, cosh_in, sinh_in, out_ready,
`ifdef TANH_SIGMOID_EN
    output sigmoid_out,
`endif
    output in_ready, out_valid, tanh_out, sat, busy
  );

  modport master (
    output in_valid, cosh_in, sinh_in, out_ready,
`ifdef TANH_SIGMOID_EN
    input  sigmoid_out,
`endif
    input  in_ready, out_valid, tanh_out, sat, busy
  );

endinterface

// File: rtl/cordic_restoring_div_step.sv
// One combinational restoring-division iteration: compare, conditionally
// subtract, then shift the partial remainder left for the next quotient bit.
module cordic_restoring_div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH:0]   rem_i,
  input  logic [DATA_WIDTH-1:0] div_i,
  output logic                  q_bit_o,
  output logic [DATA_WIDTH:0]   rem_o
);

  logic [DATA_WIDTH:0] div_ext;
  logic [DATA_WIDTH:0] diff;

  assign div_ext = {1'b0, div_i};
  assign q_bit_o = (rem_i >= div_ext);
  assign diff    = rem_i - div_ext;
  assign rem_o   = (q_bit_o ? diff : rem_i) << 1;

endmodule

// File: rtl/cordic_tanh_div.sv
// tanh = sinh/cosh by serial restoring division, one quotient bit per clock.
// Optional sigmoid output enabled by defining TANH_SIGMOID_EN.
module cordic_tanh_div
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FRAC_BITS  = FRAC_BITS_DEF
) (
  input logic               clk,
  input logic               rst_n,
  cordic_tanh_div_if.slave  bus
);

  localparam int CW = $clog2(FRAC_BITS + 1) + 1;
  localparam logic signed [DATA_WIDTH-1:0] ONE_C = DATA_WIDTH'(longint'(1) << FRAC_BITS);

  tanh_state_e                  state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         neg_q, neg_d;
  logic                         divz_q, divz_d;
  logic [DATA_WIDTH:0]          rem_q, rem_d;
  logic [DATA_WIDTH-1:0]        dvs_q, dvs_d;
  logic [FRAC_BITS:0]           quo_q, quo_d;
  logic signed [DATA_WIDTH-1:0] tanh_q, tanh_d;
  logic                         sat_q, sat_d;
  logic                         vld_q, vld_d;
`ifdef TANH_SIGMOID_EN
  logic signed [DATA_WIDTH-1:0] sig_q, sig_d;
`endif

  logic                  step_bit;
  logic [DATA_WIDTH:0]   step_rem;
  logic [FRAC_BITS:0]    quo_fin;
  logic [DATA_WIDTH-1:0] sinh_mag;
  logic [DATA_WIDTH-1:0] quo_mag;

  function automatic logic signed [DATA_WIDTH-1:0] apply_sign(
    input logic neg, input logic [DATA_WIDTH-1:0] mag);
    return neg ? -$signed(mag) : $signed(mag);
  endfunction

  cordic_restoring_div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem_i   (rem_q),
    .div_i   (dvs_q),
    .q_bit_o (step_bit),
    .rem_o   (step_rem)
  );

  // Integer quotient bit set means |sinh| >= cosh, so the magnitude clamps to one.
  assign quo_fin  = {quo_q[FRAC_BITS-1:0], step_bit};
  assign quo_mag  = quo_fin[FRAC_BITS] ? ONE_C : DATA_WIDTH'(quo_fin);
  assign sinh_mag = bus.sinh_in[DATA_WIDTH-1] ? (~bus.sinh_in + 1'b1) : bus.sinh_in;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    divz_d  = divz_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    tanh_d  = tanh_q;
    sat_d   = sat_q;
    vld_d   = vld_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          neg_d   = bus.sinh_in[DATA_WIDTH-1];
          rem_d   = {1'b0, sinh_mag};
          dvs_d   = bus.cosh_in;
          divz_d  = (bus.cosh_in <= 0);
          quo_d   = '0;
          cnt_d   = '0;
          state_d = ST_DIV;
        end
      end
      ST_DIV: begin
        // A non-positive divisor leaves after one cycle with a saturated result.
        if (divz_q) begin
          tanh_d  = apply_sign(neg_q, ONE_C);
          sat_d   = 1'b1;
          vld_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          rem_d = step_rem;
          quo_d = quo_fin;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(FRAC_BITS)) begin
            tanh_d  = apply_sign(neg_q, quo_mag);
            sat_d   = quo_fin[FRAC_BITS];
            vld_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          vld_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef TANH_SIGMOID_EN
  assign sig_d = (tanh_d + ONE_C) >>> 1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      divz_q  <= 1'b0;
      rem_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      tanh_q  <= '0;
      sat_q   <= 1'b0;
      vld_q   <= 1'b0;
`ifdef TANH_SIGMOID_EN
      sig_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      divz_q  <= divz_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      tanh_q  <= tanh_d;
      sat_q   <= sat_d;
      vld_q   <= vld_d;
`ifdef TANH_SIGMOID_EN
      sig_q   <= sig_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.out_valid = vld_q;
  assign bus.tanh_out  = tanh_q;
  assign bus.sat       = sat_q;
`ifdef TANH_SIGMOID_EN
  assign bus.sigmoid_out = sig_q;
`endif

endmodule

// File: tb/tb_cordic_tanh_div.sv
// Randomized self-checking bench for cordic_tanh_div against an arithmetic
// reference model of tanh = sinh/cosh with truncation and clamping.
module tb_cordic_tanh_div;
  import cordic_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  cordic_tanh_div_if #(.DATA_WIDTH(32)) bus ();

  cordic_tanh_div #(.DATA_WIDTH(32), .FRAC_BITS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: floor(|s| * 2^16 / c), clamp at one, apply sign of s.
  function automatic void model(input int c, input int s, output longint t, output longint st);
    longint n, q;
    if (c <= 0) begin
      st = 1;
      t  = (s < 0) ? -longint'(ONE) : longint'(ONE);
    end else begin
      n = (s < 0) ? -longint'(s) : longint'(s);
      q = (n * ONE) / c;
      st = 0;
      if (q >= ONE) begin
        q  = ONE;
        st = 1;
      end
      t = (s < 0) ? -q : q;
    end
  endfunction

  task automatic run_op(input int c, input int s, input int hold);
    longint exp_t, exp_s, exp_lat;
    int lat;
    model(c, s, exp_t, exp_s);
    exp_lat = (c <= 0) ? 1 : 17;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.cosh_in  = c;
    bus.sinh_in  = s;
    chk("in_ready_idle", longint'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    // Noise on the input side must be ignored while busy.
    bus.in_valid = 1'($urandom_range(0, 1));
    bus.cosh_in  = $urandom;
    bus.sinh_in  = $urandom;
    chk("in_ready_busy", longint'(bus.in_ready), 0);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    chk("latency", lat, exp_lat);
    chk("tanh", longint'(bus.tanh_out), exp_t);
    chk("sat", longint'(bus.sat), exp_s);
`ifdef TANH_SIGMOID_EN
    chk("sigmoid", longint'(bus.sigmoid_out), (exp_t + ONE) >>> 1);
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_tanh", longint'(bus.tanh_out), exp_t);
      chk("hold_vld_rdy", longint'({bus.out_valid, bus.in_ready}), 2);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("post_hs", longint'({bus.out_valid, bus.in_ready, bus.busy}), 2);
  endtask

  initial begin
    int c, s, mag, vcount;
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.cosh_in   = '0;
    bus.sinh_in   = '0;
    #12;
    chk("rst_outputs", longint'({bus.out_valid, bus.sat, bus.busy}), 0);
    chk("rst_tanh", longint'(bus.tanh_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", longint'(bus.in_ready), 1);

    run_op(65536, 0, 0);
    run_op(101126, 77018, 1);
    run_op(101126, -77018, 0);
    run_op(65536, 131072, 0);
    run_op(65536, -131072, 2);
    run_op(0, 1000, 0);
    run_op(-5, -7, 0);
    run_op(65536, 65536, 0);
    run_op(65536, 65535, 0);
    run_op(101126, 77018, 10);

    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 7) == 0) c = -int'($urandom_range(0, 1000));
      else c = int'($urandom_range(1, 1 << 20));
      mag = int'($urandom_range(0, 2 * ((c > 0) ? c : 1000)));
      if ($urandom_range(0, 9) == 0) mag = (c > 0) ? c : mag;
      s = $urandom_range(0, 1) ? -mag : mag;
      run_op(c, s, int'($urandom_range(0, 3)));
    end

    // Abort a division at iteration 8.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.cosh_in  = 101126;
    bus.sinh_in  = -77018;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", longint'({bus.out_valid, bus.sat, bus.busy}), 0);
    chk("midrst_tanh", longint'(bus.tanh_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) vcount++;
    end
    chk("midrst_no_valid", vcount, 0);
    run_op(101126, -77018, 0);
    run_op(101126, 77018, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
